// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight; results return over per-port valid/ready channels.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             alu_en,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             alu_valid,
    output logic             busy,
    output logic [CNTW-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_result;
    logic [CNTW-1:0]  r_ops;
    logic             w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_rsp_hs;

    // Tie goes to the port that did not win the previous accept.
    assign w_grant  = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    assign w_idle   = (r_state == IDLE);
    assign req0_ready = w_idle && !w_grant;
    assign req1_ready = w_idle && w_grant;
    assign w_accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp0_valid = (r_state == RESP) && !r_owner;
    assign rsp1_valid = (r_state == RESP) && r_owner;
    assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign rsp_data = r_result;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_op   = r_op;
    assign busy     = !w_idle;
    assign ops_done = r_ops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        alu_en = 1'b0;
        unique case (r_state)
            IDLE:  if (w_accept) w_next = ISSUE;
            ISSUE: begin
                alu_en = 1'b1;
                w_next = WAIT;
            end
            WAIT:  if (alu_valid) w_next = RESP;
            RESP:  if (w_rsp_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_ops    <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_last  <= w_grant;
                r_a     <= w_grant ? req1_a : req0_a;
                r_b     <= w_grant ? req1_b : req0_b;
                r_op    <= w_grant ? req1_op : req0_op;
            end
            if (r_state == WAIT && alu_valid) begin
                r_result <= alu_data;
            end
            if (w_rsp_hs) begin
                r_ops <= r_ops + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered one-cycle ALU model.
// Counter width is reduced to 4 so the wrap case is reachable.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;
    localparam int CNTW  = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             alu_en;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_data;
    logic             alu_valid;
    logic             busy;
    logic [CNTW-1:0]  ops_done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(
        .WIDTH(WIDTH),
        .OPW  (OPW),
        .CNTW (CNTW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready),
        .rsp_data  (rsp_data),
        .alu_en    (alu_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_data  (alu_data),
        .alu_valid (alu_valid),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: opcode 1 add, 2 subtract, anything else xor.
    function automatic logic [WIDTH-1:0] alu_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [OPW-1:0]   op
    );
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid <= 1'b0;
            alu_data  <= '0;
        end else begin
            alu_valid <= alu_en;
            if (alu_en) alu_data <= alu_f(alu_a, alu_b, alu_op);
        end
    end

    task automatic clear_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || alu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%0b alu_en=%0b want 0 0", busy, alu_en);
        end
        n_checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: rsp0_valid=%0b rsp1_valid=%0b want 0 0", rsp0_valid, rsp1_valid);
        end
        n_checks++;
        if (ops_done !== 4'd0 || rsp_data !== 32'd0 || alu_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: ops_done=%0d rsp_data=%0d alu_a=%0d want 0", ops_done, rsp_data, alu_a);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single();
        rsp0_ready = 1;
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 5'b00001;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: req0_ready=%0b req1_ready=%0b want 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        #1;
        n_checks++;
        if (alu_en !== 1'b1 || busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
            n_fail++;
            $display("FAIL single_issue: alu_en=%0b busy=%0b a=%0d b=%0d want 1 1 5 3", alu_en, busy, alu_a, alu_b);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (alu_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wait: alu_en=%0b busy=%0b want 0 1", alu_en, busy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'd8) begin
            n_fail++;
            $display("FAIL single_rsp: rsp0_valid=%0b rsp1_valid=%0b data=%0d want 1 0 8", rsp0_valid, rsp1_valid, rsp_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ops_done !== 4'd1 || busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: ops_done=%0d busy=%0b rsp0_valid=%0b want 1 0 0", ops_done, busy, rsp0_valid);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 10; req0_b = 4; req0_op = 5'd2;
        req1_valid = 1; req1_a = 1;  req1_b = 1; req1_op = 5'd1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_grant: req0_ready=%0b req1_ready=%0b want 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'd6) begin
            n_fail++;
            $display("FAIL tie_rsp0: rsp0_valid=%0b rsp1_valid=%0b data=%0d want 1 0 6", rsp0_valid, rsp1_valid, rsp_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second: req1_ready=%0b req0_ready=%0b want 1 0", req1_ready, req0_ready);
        end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== 32'd2) begin
            n_fail++;
            $display("FAIL tie_rsp1: rsp1_valid=%0b rsp0_valid=%0b data=%0d want 1 0 2", rsp1_valid, rsp0_valid, rsp_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ops_done !== 4'd2) begin
            n_fail++;
            $display("FAIL tie_count: ops_done=%0d want 2", ops_done);
        end
    endtask

    task automatic test_fairness();
        int cnt0;
        int cnt1;
        int port;
        cnt0 = 0;
        cnt1 = 0;
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 3;  req0_b = 4; req0_op = 5'd1;
        req1_valid = 1; req1_a = 20; req1_b = 5; req1_op = 5'd2;
        for (int i = 0; i < 8; i++) begin
            port = i % 2;
            #1;
            n_checks++;
            if (req0_ready !== (port == 0) || req1_ready !== (port == 1)) begin
                n_fail++;
                $display("FAIL fair_grant%0d: req0_ready=%0b req1_ready=%0b want port %0d", i, req0_ready, req1_ready, port);
            end
            repeat (3) @(negedge clk);
            #1;
            if (rsp0_valid === 1'b1) cnt0++;
            if (rsp1_valid === 1'b1) cnt1++;
            n_checks++;
            if (rsp_data !== (port == 0 ? 32'd7 : 32'd15)) begin
                n_fail++;
                $display("FAIL fair_data%0d: data=%0d want %0d", i, rsp_data, port == 0 ? 7 : 15);
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        #1;
        n_checks++;
        if (cnt0 != 4 || cnt1 != 4 || ops_done !== 4'd8) begin
            n_fail++;
            $display("FAIL fair_totals: port0=%0d port1=%0d ops_done=%0d want 4 4 8", cnt0, cnt1, ops_done);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp0_ready = 1; rsp1_ready = 0;
        req1_valid = 1; req1_a = 100; req1_b = 1; req1_op = 5'd2;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept1: req1_ready=%0b want 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 0;
        req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 5'd1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (rsp1_valid !== 1'b1 || rsp_data !== 32'd99 || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: rsp1_valid=%0b data=%0d req0_ready=%0b want 1 99 0", k, rsp1_valid, rsp_data, req0_ready);
            end
        end
        @(negedge clk);
        rsp1_ready = 1;
        #1;
        n_checks++;
        if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rsp1_valid=%0b req0_ready=%0b want 1 0", rsp1_valid, req0_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept0: req0_ready=%0b rsp1_valid=%0b want 1 0", req0_ready, rsp1_valid);
        end
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 32'd4) begin
            n_fail++;
            $display("FAIL bp_rsp0: rsp0_valid=%0b data=%0d want 1 4", rsp0_valid, rsp_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ops_done !== 4'd2) begin
            n_fail++;
            $display("FAIL bp_count: ops_done=%0d want 2", ops_done);
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        rsp0_ready = 1;
        req0_valid = 1; req0_a = 3; req0_b = 3; req0_op = 5'd1;
        @(negedge clk);
        req0_valid = 0;
        repeat (3) @(negedge clk);
        req0_valid = 1; req0_a = 7; req0_b = 8; req0_op = 5'd1;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || ops_done !== 4'd1 || rsp_data !== 32'd6) begin
            n_fail++;
            $display("FAIL mid_pre: busy=%0b ops_done=%0d data=%0d want 1 1 6", busy, ops_done, rsp_data);
        end
        rst = 1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || alu_en !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ctrl: busy=%0b alu_en=%0b rsp0=%0b rsp1=%0b want 0", busy, alu_en, rsp0_valid, rsp1_valid);
        end
        n_checks++;
        if (ops_done !== 4'd0 || rsp_data !== 32'd0 || alu_a !== 32'd0 || alu_op !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_data: ops_done=%0d data=%0d alu_a=%0d alu_op=%0d want 0", ops_done, rsp_data, alu_a, alu_op);
        end
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_quiet%0d: rsp0_valid=%0b busy=%0b want 0 0", k, rsp0_valid, busy);
            end
        end
        req0_valid = 1; req0_a = 6; req0_b = 6; req0_op = 5'd1;
        @(negedge clk);
        req0_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 32'd12) begin
            n_fail++;
            $display("FAIL mid_next: rsp0_valid=%0b data=%0d want 1 12", rsp0_valid, rsp_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ops_done !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_count: ops_done=%0d want 1", ops_done);
        end
    endtask

    task automatic test_counter_wrap();
        logic [CNTW-1:0] exp_cnt;
        apply_reset();
        rsp0_ready = 1;
        for (int i = 0; i < 17; i++) begin
            req0_valid = 1; req0_a = i; req0_b = 1; req0_op = 5'd1;
            @(negedge clk);
            req0_valid = 0;
            repeat (2) @(negedge clk);
            #1;
            n_checks++;
            if (rsp0_valid !== 1'b1 || rsp_data !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL wrap_data%0d: rsp0_valid=%0b data=%0d want 1 %0d", i, rsp0_valid, rsp_data, i + 1);
            end
            @(negedge clk);
            #1;
            exp_cnt = CNTW'((i + 1) % 16);
            n_checks++;
            if (ops_done !== exp_cnt) begin
                n_fail++;
                $display("FAIL wrap_count%0d: ops_done=%0d want %0d", i, ops_done, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_reset_mid_op();
        test_counter_wrap();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle `alu` datapath between two requesters, for example the fetch-side PC/address path (port 0) and the execute stage (port 1). Each requester presents an operand/opcode transaction over a valid/ready handshake. The block grants requesters round-robin, issues one operation to the ALU and captures the registered result. It then returns the result to the owning requester over a valid/ready response channel, with only one operation in flight at a time.

## Interface
- `WIDTH`, 32: operand/result width.
- `OPW`, 5: opcode width, matching the ALU `operation` port.
- `CNTW`, 16: width of the completed-operation counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high together with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_op` / `req1_op`  in  OPW  ALU opcode.
- `rsp0_valid` / `rsp1_valid`  out  1  result available to that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp_data`  out  WIDTH  result, shared by both response channels; meaningful only under `rspN_valid`.
- `alu_en`  out  1  drives the ALU `en` input.
- `alu_a`, `alu_b`  out  WIDTH  drive the ALU `port_A` and `port_B` inputs.
- `alu_op`  out  OPW  drives the ALU `operation` input.
- `alu_data`  in  WIDTH  ALU `data_out`.
- `alu_valid`  in  1  ALU `valid`.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  CNTW  count of completed response handshakes; wraps modulo 2^CNTW.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: `reqN_ready` is combinational and equals `(state==IDLE) && grant==N`.
  - Grant rule: if only one `reqN_valid` is high, that port is granted.
  - If both are high, the port not equal to `last` is granted.
  - `last` resets to 1, so port 0 wins the first tie.
- Accept (valid and ready in IDLE):
  - Register the operands and opcode into `alu_a`, `alu_b`, `alu_op`.
  - Record the owner port and set `last` to the owner.
  - Go to ISSUE.
- ISSUE: `alu_en`=1 for exactly this cycle; go to WAIT.
- WAIT: `alu_en`=0.
  - When `alu_valid`=1, capture `alu_data` into the result register and go to RESP.
  - Otherwise stay in WAIT; there is no timeout.
- RESP: `rsp<owner>_valid`=1 and `rsp_data` = result register; the other port's `rspN_valid` stays 0.
  - On `rsp<owner>_ready`=1: increment `ops_done` and go to IDLE.
  - Otherwise hold the state, with `rsp_data` stable.
- `alu_a`, `alu_b`, `alu_op` hold their values from accept until the next accept.
- Requests are never accepted outside IDLE; requesters must keep valid and payload stable until ready.
- Opcodes are passed through unchecked. Decode, flags and illegal-op handling belong to the ALU.
- `ops_done` wraps from 2^CNTW-1 to 0 with no saturation or flag.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE, `last` to 1.
  - `alu_en`, both `rspN_valid`, `busy` and `ops_done` go to 0; `alu_a`, `alu_b`, `alu_op`, `rsp_data` go to 0.
  - Any in-flight result is discarded.
  - The ALU shares `rst` and clears on the next edge; a stale `alu_valid` seen in IDLE is ignored.
- Latency, with accept in cycle T:
  - `alu_en` high in T+1.
  - `alu_valid` high in T+2.
  - `rspN_valid` high from T+3.
- With the response taken in T+3, the next accept can occur in T+4. Peak throughput is one operation per 4 cycles.
- `rspN_ready` may be high before `rspN_valid`. The handshake completes in the first RESP cycle.
- A requester that deasserts valid before ready loses nothing; the arbitration pointer updates only on accept.
- Both ready outputs are never high in the same cycle.
- `busy` is registered from state: it is 1 from T+1 until the cycle after the response handshake.

## Test plan
- Single op: port 0 requests op 5'b00001, a=5, b=3, `rsp0_ready`=1 → `req0_ready` high in T; `alu_en` high only in T+1; `rsp0_valid`=1 with `rsp_data`=8 in T+3; `ops_done`=1.
- Tie after reset: both ports valid (port 0 subtract 10-4, port 1 add 1+1) → port 0 served first (`rsp_data`=6). Port 1 is accepted in the next IDLE cycle, T+4, returning `rsp_data`=2 in T+7.
- Fairness: both ports held valid for 8 operations → grants alternate 0,1,0,1…; each port completes 4 operations; `ops_done`=8.
- Backpressure: `rsp1_ready`=0 for 5 RESP cycles while port 0 is valid → `rsp1_valid` and `rsp_data` stay stable; `req0_ready`=0 throughout. Port 0 is accepted the cycle after `rsp1_ready` rises.
- Reset mid-operation: assert `rst` in WAIT → all outputs 0 immediately and no `rspN_valid` afterwards. The next request completes normally with correct data.
- Counter wrap: CNTW=4, run 17 operations → `ops_done` reads 15 then 0 then 1.
